cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
- Run controller that sequences the single-cycle MIPS core, its instruction memory and its data-memory bus.
- Holds the core in reset while a host loads program words into instruction memory over a valid/ready port.
- Releases the core on start and counts executed cycles.
- Stops the core on a store to a halt mailbox address or on timeout, and captures the stored word as the run result.

Parameters:
- IMEM_AW, 6, instruction-memory word-address width (64 words, indexed by pc[7:2]).
- HALT_ADDR, 32'h0000_00FC, data address whose store ends a run.
- MAX_CYCLES, 1024, RUN cycles allowed before timeout; must be ≥ 1.
- CNT_W, 16, width of the cycle counter; 2^CNT_W must exceed MAX_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled each cycle; begins a run from IDLE or DONE.
- load_valid  in  1  host program-word valid.
- load_ready  out  1  controller accepts a program word.
- load_addr  in  IMEM_AW  word address of the program word.
- load_data  in  32  program word.
- imem_we  out  1  instruction-memory write strobe.
- imem_wa  out  IMEM_AW  instruction-memory write word address.
- imem_wd  out  32  instruction-memory write data.
- cpu_reset  out  1  reset driven to the core.
- memwrite  in  1  core data-store strobe.
- dataadr  in  32  core data address.
- writedata  in  32  core store data.
- busy  out  1  high in RUN.
- done  out  1  run ended by halt store.
- timeout  out  1  run ended by cycle limit.
- result  out  32  writedata captured at the halt store.
- cycles  out  CNT_W  RUN cycles elapsed in the current or last run.

Behaviour:
- States: IDLE, RUN, DONE; encoding comes from the package.
- Reset:
  - state = IDLE, cpu_reset = 1, imem_we = 0; imem_wa, imem_wd, result and cycles = 0; busy, done and timeout = 0.
  - Reset asserted mid-run takes effect immediately: the core returns to reset with no result capture.
- load_ready: combinational; 1 in IDLE or DONE while start = 0, else 0. start therefore has priority over a same-cycle load beat, and that beat is not accepted.
- Load beat: accepted on load_valid & load_ready.
  - The following cycle drives imem_we = 1 with imem_wa/imem_wd equal to the registered beat (1-cycle latency).
  - Otherwise imem_we = 0. Back-to-back beats are accepted every cycle.
  - A beat accepted in DONE clears done, timeout and result and moves to IDLE.
- Start from IDLE or DONE:
  - Next state is RUN; cpu_reset goes 0 and busy goes 1 on the same edge.
  - cycles, done, timeout and result are cleared.
  - If the last load beat was accepted the cycle before start, its imem write occurs in the first RUN cycle; the core's first fetch is address 0, so loaders must finish with a 1-cycle gap or load word 0 earlier.
- RUN:
  - cycles increments by 1 per cycle.
  - Halt: memwrite & (dataadr == HALT_ADDR). On the next edge: result = writedata, done = 1, cpu_reset = 1, busy = 0, state = DONE.
  - Timeout: when cycles == MAX_CYCLES-1 and no halt, on the next edge: timeout = 1, cpu_reset = 1, busy = 0, state = DONE.
  - Halt and timeout in the same cycle: halt wins, timeout stays 0.
  - A store to any other address is ignored by the controller.
  - start is ignored while in RUN.
- DONE: cpu_reset = 1; result, cycles, done and timeout hold until the next start or accepted load beat.
- cycles saturates logically at MAX_CYCLES and never wraps, given the CNT_W rule.
- done and timeout are never both 1.

Decomposition:
- Package cpu_run_pkg holds:
  - the state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - default HALT_ADDR and MAX_CYCLES constants;
  - IMEM_AW default.
- One natural sub-module, run_cycle_counter: clear, enable and terminal-count compare, parameterised by CNT_W and MAX_CYCLES.
- The FSM, load register and result capture stay in cpu_run_ctrl.

Test Plan:
- Reset check: assert reset mid-RUN at an arbitrary phase -> cpu_reset = 1 and busy = 0 immediately; after release, state is IDLE with all outputs zero.
- Load: 3 back-to-back beats (addr 0/1/2, data 0x20080005/0x2009000A/0xAC0800FC) -> imem_we high for exactly 3 cycles, one cycle after each accept, with matching imem_wa/imem_wd; load_ready stays 1.
- Halt run: load the program, gap, start -> cpu_reset drops next edge; the store of 5 to 0xFC leads to result = 5, done = 1, timeout = 0, cpu_reset = 1; cycles equals the instruction count to the store.
- Timeout: MAX_CYCLES = 8, program loops with no halt store -> timeout = 1 after exactly 8 RUN cycles, cycles = 7 or 8 per counter spec, done = 0.
- Priority: start and load_valid high together in IDLE -> load_ready = 0, no imem_we, enters RUN. Halt store on the timeout cycle -> done = 1, timeout = 0.
- Rerun from DONE: start without reload -> cycles and result cleared, same result reproduced. Load beat in DONE -> done cleared, state IDLE.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared definitions for the MIPS run controller: state encoding and default parameters.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } run_state_t;

    localparam logic [31:0] DEF_HALT_ADDR  = 32'h0000_00FC;
    localparam int          DEF_MAX_CYCLES = 1024;
    localparam int          DEF_IMEM_AW    = 6;
    localparam int          DEF_CNT_W      = 16;

endpackage

// File: rtl/cpu_run_ctrl_counter.sv
// RUN-cycle counter with synchronous clear, enable and a terminal-count flag
// that fires on the last permitted RUN cycle.
module run_cycle_counter #(
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MAX_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Holds at MAX_CYCLES so the count can never wrap back to a small value.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LP_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == LP_LAST);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: loads instruction memory while the core is held in reset,
// runs it until a halt-mailbox store or the cycle limit, and keeps the result.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int          IMEM_AW    = DEF_IMEM_AW,
    parameter logic [31:0] HALT_ADDR  = DEF_HALT_ADDR,
    parameter int          MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int          CNT_W      = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [IMEM_AW-1:0] load_addr,
    input  logic [31:0]        load_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_wa,
    output logic [31:0]        imem_wd,
    output logic               cpu_reset,
    input  logic               memwrite,
    input  logic [31:0]        dataadr,
    input  logic [31:0]        writedata,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [31:0]        result,
    output logic [CNT_W-1:0]   cycles
);

    run_state_t          r_state;
    logic                r_imem_we;
    logic [IMEM_AW-1:0]  r_imem_wa;
    logic [31:0]         r_imem_wd;
    logic                r_cpu_reset;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout;
    logic [31:0]         r_result;

    logic w_stopped;
    logic w_start;
    logic w_accept;
    logic w_running;
    logic w_halt;
    logic w_tc;

    assign w_stopped  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start    = w_stopped && start;
    // start wins over a same-cycle load beat by withdrawing ready.
    assign load_ready = w_stopped && !start;
    assign w_accept   = load_valid && load_ready;
    assign w_running  = (r_state == ST_RUN);
    assign w_halt     = w_running && memwrite && (dataadr == HALT_ADDR);

    run_cycle_counter #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_counter (
        .clk     (clk),
        .i_rst   (reset),
        .i_clr   (w_start),
        .i_en    (w_running),
        .o_count (cycles),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_imem_we   <= 1'b0;
            r_imem_wa   <= '0;
            r_imem_wd   <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_result    <= '0;
        end else begin
            r_imem_we <= w_accept;
            if (w_accept) begin
                r_imem_wa <= load_addr;
                r_imem_wd <= load_data;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_state     <= ST_RUN;
                        r_cpu_reset <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_result    <= '0;
                    end else if (w_accept) begin
                        r_state   <= ST_IDLE;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_result  <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_halt) begin
                        r_state     <= ST_DONE;
                        r_result    <= writedata;
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (w_tc) begin
                        r_state     <= ST_DONE;
                        r_timeout   <= 1'b1;
                        r_cpu_reset <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cpu_reset <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign imem_we   = r_imem_we;
    assign imem_wa   = r_imem_wa;
    assign imem_wd   = r_imem_wd;
    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign result    = r_result;

endmodule
